// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin share of one rectangle engine between
// NREQ object requesters, one-cycle ack per finished or skipped object.
module draw_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] x_in,
  input  logic [7*NREQ-1:0] y_in,
  input  logic [5*NREQ-1:0] width,
  input  logic [5*NREQ-1:0] height,
  input  logic [3*NREQ-1:0] c_in,
  input  logic              drw_done,
  output logic [7:0]        drw_x,
  output logic [6:0]        drw_y,
  output logic [4:0]        drw_w,
  output logic [4:0]        drw_h,
  output logic [2:0]        drw_c,
  output logic              drw_enable,
  output logic              plot,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_ACK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_win;
  logic [PW-1:0]   w_pick;
  logic            w_found;
  logic            w_load;
  logic [NREQ-1:0] r_grant;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [4:0] r_w;
  logic [4:0] r_h;
  logic [2:0] r_c;

  logic [7:0] w_x;
  logic [6:0] w_y;
  logic [4:0] w_w;
  logic [4:0] w_h;
  logic [2:0] w_c;

  // first requester at or after the pointer, wrapping
  always_comb begin : search
    int t;
    w_found = 1'b0;
    w_pick  = '0;
    t       = 0;
    for (int k = 0; k < NREQ; k++) begin
      t = int'(r_ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!w_found && req[t]) begin
        w_found = 1'b1;
        w_pick  = PW'(t);
      end
    end
  end

  always_comb begin
    w_x = x_in[int'(w_pick)*8 +: 8];
    w_y = y_in[int'(w_pick)*7 +: 7];
    w_w = width[int'(w_pick)*5 +: 5];
    w_h = height[int'(w_pick)*5 +: 5];
    w_c = c_in[int'(w_pick)*3 +: 3];
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load = 1'b1;
          if (w_w == 5'd0 || w_h == 5'd0) w_next = S_ACK;
          else                            w_next = S_DRAW;
        end
      end
      S_DRAW: begin
        if (drw_done) w_next = S_ACK;
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_win   <= w_pick;
        r_grant <= NREQ'(1) << w_pick;
        r_x     <= w_x;
        r_y     <= w_y;
        r_w     <= w_w;
        r_h     <= w_h;
        r_c     <= w_c;
      end
      if (r_state == S_ACK) begin
        r_grant <= '0;
        r_ptr   <= (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);
      end
    end
  end

  // combinational so the engine never starts a second pass on done
  assign drw_enable = (r_state == S_DRAW) && !drw_done;
  assign plot       = drw_enable;
  assign ack        = (r_state == S_ACK) ? r_grant : '0;
  assign busy       = (r_state != S_IDLE);
  assign grant      = r_grant;
  assign drw_x      = r_x;
  assign drw_y      = r_y;
  assign drw_w      = r_w;
  assign drw_h      = r_h;
  assign drw_c      = r_c;

endmodule
